// File: rtl/maze_depth_pkg.sv
// rtl/maze_depth_pkg.sv - shared types and constants for the depth resolve stage
// Purpose: depth buffer entry layout, cleared-entry constant, FSM state enum,
//          and the nearest-sample accept rule shared by the resolve pipeline.
// Ports:   none (package)
package maze_depth_pkg;

   localparam int DEPTH_CRD_W = 10;

   typedef struct packed {
      logic                   valid;
      logic [DEPTH_CRD_W-1:0] x;
      logic [DEPTH_CRD_W-1:0] y;
      logic [DEPTH_CRD_W-1:0] z;
   } depth_entry_t;

   // Farthest representable depth: largest positive signed value.
   localparam logic [DEPTH_CRD_W-1:0] Z_FAR = {1'b0, {(DEPTH_CRD_W-1){1'b1}}};

   localparam depth_entry_t CLEAR_ENTRY = '{valid: 1'b0, x: '0, y: '0, z: Z_FAR};

   typedef enum logic {CLEAR, RUN} fsm_state_t;

   // Non-negative depth that is strictly nearer than the stored entry (or the
   // entry is empty). Equal depth keeps the existing entry.
   function automatic logic depth_accept(input logic [DEPTH_CRD_W-1:0] z,
                                         input depth_entry_t           cur);
      return !z[DEPTH_CRD_W-1] && (!cur.valid || ($signed(z) < $signed(cur.z)));
   endfunction

endpackage

// File: rtl/depth_ram.sv
// rtl/depth_ram.sv - depth buffer: one write port, two registered read ports
// Purpose: 2**AW entry storage. Both read ports return the entry as it was
//          before a same-cycle write to the same address (read-old-data).
// Ports:   clk_i, rst_i         clock, sync active-high reset of read registers
//          wr_en_i/addr_i/data_i write port
//          rs_addr_i/rs_data_o  resolve read port (1-cycle latency)
//          dp_addr_i/dp_data_o  display read port (1-cycle latency)
module depth_ram
   import maze_depth_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  depth_entry_t  wr_data_i,
   input  logic [AW-1:0] rs_addr_i,
   output depth_entry_t  rs_data_o,
   input  logic [AW-1:0] dp_addr_i,
   output depth_entry_t  dp_data_o
);

   depth_entry_t mem_q [2**AW];
   depth_entry_t rs_q;
   depth_entry_t dp_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rs_q <= '0;
         dp_q <= '0;
      end else begin
         rs_q <= mem_q[rs_addr_i];
         dp_q <= mem_q[dp_addr_i];
      end
   end

   assign rs_data_o = rs_q;
   assign dp_data_o = dp_q;

endmodule

// File: rtl/depth_resolve.sv
// rtl/depth_resolve.sv - per-pixel nearest-sample depth resolve with clear sweep
// Purpose: keeps the nearest valid (x,y,z) sample per pixel in a depth buffer,
//          cleared by a hardware sweep on reset and on every frame_start.
// Build option: DEPTH_STATS_EN adds a saturating accepted-write counter.
// Ports:   clk, rst                 clock, sync active-high reset
//          frame_start              restart clear sweep, discard in-flight samples
//          in_en/in_p/in_x/y/z      sample stream (z is signed depth)
//          busy                     clear sweep in progress, samples dropped
//          rd_p -> rd_valid/x/y/z   display read, 1-cycle latency
//          stat_hits                accepted writes since last clear
module depth_resolve
   import maze_depth_pkg::*;
#(
   parameter int PIX_W = 10,
   parameter int CRD_W = DEPTH_CRD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             in_en,
   input  logic [PIX_W-1:0] in_p,
   input  logic [CRD_W-1:0] in_x,
   input  logic [CRD_W-1:0] in_y,
   input  logic [CRD_W-1:0] in_z,
   output logic             busy,
   input  logic [PIX_W-1:0] rd_p,
   output logic             rd_valid,
   output logic [CRD_W-1:0] rd_x,
   output logic [CRD_W-1:0] rd_y,
   output logic [CRD_W-1:0] rd_z,
   output logic [PIX_W:0]   stat_hits
);

   fsm_state_t       state_q;
   logic [PIX_W-1:0] addr_q;
   logic             busy_q;

   logic             run;

   // S1: registered sample, resolve read issued at s1_p_q.
   logic             s1_v_q;
   logic [PIX_W-1:0] s1_p_q;
   depth_entry_t     s1_e_q;
   // S2: read data available, compare and conditional write.
   logic             s2_v_q;
   logic [PIX_W-1:0] s2_p_q;
   depth_entry_t     s2_e_q;
   logic             s2_fwd_q;
   depth_entry_t     s2_fwd_e_q;

   depth_entry_t     rs_data;
   depth_entry_t     dp_data;
   depth_entry_t     s2_stored;
   logic             s2_we;

   logic             wr_en;
   logic [PIX_W-1:0] wr_addr;
   depth_entry_t     wr_data;

   // Reset parks the FSM in CLEAR with busy low for one cycle so every output
   // reads 0 right after reset; the sweep itself starts on the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         addr_q  <= '0;
         busy_q  <= 1'b0;
      end else if (frame_start) begin
         state_q <= CLEAR;
         addr_q  <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               if (!busy_q) begin
                  busy_q <= 1'b1;
               end else if (addr_q == '1) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
                  addr_q  <= '0;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            RUN: begin
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

   // A frame_start cycle flushes the pipeline and blocks the pending write.
   assign run = (state_q == RUN) && !frame_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s2_fwd_q <= 1'b0;
      end else begin
         s1_v_q   <= run && in_en;
         s2_v_q   <= run && s1_v_q;
         // The S1 read of an address S2 is writing returns stale data;
         // remember the written entry so S2 can use it instead.
         s2_fwd_q <= s2_we && (s1_p_q == s2_p_q);
      end
      s1_p_q     <= in_p;
      s1_e_q     <= '{valid: 1'b1, x: in_x, y: in_y, z: in_z};
      s2_p_q     <= s1_p_q;
      s2_e_q     <= s1_e_q;
      s2_fwd_e_q <= s2_e_q;
   end

   assign s2_stored = s2_fwd_q ? s2_fwd_e_q : rs_data;
   assign s2_we     = run && s2_v_q && depth_accept(s2_e_q.z, s2_stored);

   // The sweep owns the write port while busy; the pipeline is idle then.
   assign wr_en   = busy_q || s2_we;
   assign wr_addr = busy_q ? addr_q : s2_p_q;
   assign wr_data = busy_q ? CLEAR_ENTRY : s2_e_q;

   depth_ram #(
      .AW(PIX_W)
   ) u_ram (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rs_addr_i (s1_p_q),
      .rs_data_o (rs_data),
      .dp_addr_i (rd_p),
      .dp_data_o (dp_data)
   );

   assign rd_valid = dp_data.valid;
   assign rd_x     = dp_data.x;
   assign rd_y     = dp_data.y;
   assign rd_z     = dp_data.z;

`ifdef DEPTH_STATS_EN
   logic [PIX_W:0] hits_q;
   logic [PIX_W:0] hits_d;

   always_comb begin
      hits_d = hits_q;
      if (s2_we && (hits_q != '1)) begin
         hits_d = hits_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || frame_start) begin
         hits_q <= '0;
      end else begin
         hits_q <= hits_d;
      end
   end

   assign stat_hits = hits_q;
`else
   assign stat_hits = '0;
`endif

endmodule

// File: tb/tb_depth_resolve.sv
// tb/tb_depth_resolve.sv - directed table-driven bench for depth_resolve
module tb_depth_resolve;

   localparam int PW = 10;
   localparam int CW = 10;
   localparam int SWEEP = 1 << PW;
   localparam int ZFAR = (1 << (CW - 1)) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic          in_en = 1'b0;
   logic [PW-1:0] in_p = '0;
   logic [CW-1:0] in_x = '0;
   logic [CW-1:0] in_y = '0;
   logic [CW-1:0] in_z = '0;
   logic          busy;
   logic [PW-1:0] rd_p = '0;
   logic          rd_valid;
   logic [CW-1:0] rd_x;
   logic [CW-1:0] rd_y;
   logic [CW-1:0] rd_z;
   logic [PW:0]   stat_hits;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int p, x, y, z;
      int ev, ex, ey, ez;
   } vec_t;

   vec_t tbl[8];

   depth_resolve #(.PIX_W(PW), .CRD_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .in_en       (in_en),
      .in_p        (in_p),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_z        (in_z),
      .busy        (busy),
      .rd_p        (rd_p),
      .rd_valid    (rd_valid),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_z        (rd_z),
      .stat_hits   (stat_hits)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] c(input int v);
      logic [CW-1:0] t;
      t = v[CW-1:0];
      return 32'(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int p, input int x, input int y, input int z);
      in_en = 1'b1;
      in_p  = p[PW-1:0];
      in_x  = x[CW-1:0];
      in_y  = y[CW-1:0];
      in_z  = z[CW-1:0];
   endtask

   task automatic send(input int p, input int x, input int y, input int z);
      drive(p, x, y, z);
      step();
      in_en = 1'b0;
   endtask

   task automatic settle();
      repeat (3) step();
   endtask

   task automatic read_chk(input string tag, input int p, input int ev,
                           input int ex, input int ey, input int ez);
      rd_p = p[PW-1:0];
      step();
      chk({tag, ".valid"}, 32'(rd_valid), 32'(ev));
      chk({tag, ".x"}, 32'(rd_x), c(ex));
      chk({tag, ".y"}, 32'(rd_y), c(ey));
      chk({tag, ".z"}, 32'(rd_z), c(ez));
   endtask

   // Counts busy cycles until busy falls; optionally floods samples meanwhile.
   task automatic wait_sweep(input bit junk, output int n);
      n = 0;
      for (int i = 0; i < 3000; i++) begin
         if (busy) begin
            n++;
            if (junk) drive(4, 1, 1, 1);
         end else if (n > 0) begin
            break;
         end
         step();
      end
      in_en = 1'b0;
   endtask

   initial begin
      int n;
      int exp_hits;

      tbl[0] = '{10,  3,  7,   40, 1,  3,  7,   40};
      tbl[1] = '{11,  1,  1,   -1, 0,  0,  0, ZFAR};
      tbl[2] = '{10,  9,  9,   40, 1,  3,  7,   40};
      tbl[3] = '{10,  5,  6,   39, 1,  5,  6,   39};
      tbl[4] = '{12, -2, -3,    0, 1, -2, -3,    0};
      tbl[5] = '{12,  1,  1,    0, 1, -2, -3,    0};
      tbl[6] = '{1023, 4, 4, ZFAR, 1,  4,  4, ZFAR};
      tbl[7] = '{0,   7,  8, -512, 0,  0,  0, ZFAR};

      // Reset: outputs zero, then a full-length sweep.
      step();
      step();
      chk("rst.busy", 32'(busy), 0);
      chk("rst.rd_valid", 32'(rd_valid), 0);
      chk("rst.rd_z", 32'(rd_z), 0);
      chk("rst.stat_hits", 32'(stat_hits), 0);
      rst = 1'b0;
      wait_sweep(1'b0, n);
      chk("rst.sweep_len", 32'(n), 32'(SWEEP));
      read_chk("rst.p5", 5, 0, 0, 0, ZFAR);

      // Write-to-display latency and read-old-data on collision.
      rd_p = 10'd40;
      drive(40, 2, 2, 17);
      step();
      in_en = 1'b0;
      step();
      step();
      chk("lat.old_valid", 32'(rd_valid), 0);
      step();
      chk("lat.new_valid", 32'(rd_valid), 1);
      chk("lat.new_z", 32'(rd_z), c(17));

      // Isolated samples.
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].z);
         settle();
         read_chk($sformatf("vec%0d", i), tbl[i].p, tbl[i].ev, tbl[i].ex, tbl[i].ey, tbl[i].ez);
      end

      // Back-to-back same-pixel samples must resolve as if serialised.
      drive(30, 1, 1, 40); step(); drive(30, 2, 2, 20); step(); in_en = 1'b0;
      settle();
      read_chk("b2b.far_near", 30, 1, 2, 2, 20);
      drive(31, 1, 1, 20); step(); drive(31, 2, 2, 40); step(); in_en = 1'b0;
      settle();
      read_chk("b2b.near_far", 31, 1, 1, 1, 20);
      drive(32, 1, 5, 20); step(); drive(32, 9, 9, 20); step(); in_en = 1'b0;
      settle();
      read_chk("b2b.tie", 32, 1, 1, 5, 20);
      drive(33, 1, 1, 30); step(); drive(33, 2, 2, 20); step(); drive(33, 3, 3, 25); step();
      in_en = 1'b0;
      settle();
      read_chk("b2b.three", 33, 1, 2, 2, 20);

      // frame_start mid-sweep restarts from 0; samples during busy dropped.
      frame_start = 1'b1; step(); frame_start = 1'b0;
      repeat (100) step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      wait_sweep(1'b1, n);
      chk("restart.sweep_len", 32'(n), 32'(SWEEP));
      read_chk("restart.p4", 4, 0, 0, 0, ZFAR);
      read_chk("restart.p30", 30, 0, 0, 0, ZFAR);

      // frame_start with a sample in S1 discards it.
      send(3, 6, 6, 10);
      settle();
      read_chk("flush.pre", 3, 1, 6, 6, 10);
      drive(3, 7, 7, 5);
      step();
      in_en = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      wait_sweep(1'b0, n);
      chk("flush.sweep_len", 32'(n), 32'(SWEEP));
      read_chk("flush.p3", 3, 0, 0, 0, ZFAR);

      // Accepted-write statistics.
      for (int i = 0; i < 5; i++) send(20 + i, i, i, 5);
      send(20, 9, 9, 9);
      send(25, 9, 9, -3);
      settle();
`ifdef DEPTH_STATS_EN
      exp_hits = 5;
`else
      exp_hits = 0;
`endif
      chk("stats.hits", 32'(stat_hits), 32'(exp_hits));
      read_chk("stats.p20", 20, 1, 0, 0, 5);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("stats.cleared", 32'(stat_hits), 0);
      chk("stats.busy", 32'(busy), 1);
      wait_sweep(1'b0, n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
